scan_chain_driver: RTL
======================

// Module: scan_chain_driver
// PURPOSE
//  Master end of the scan_chain interface. Accepts parallel write words over a valid/ready request port and serializes
//  them MSB-first into a scan_chain via scan_en/scan_in. Captures the chain's previous contents from scan_out into a read
//  word returned on a response port. Also sequences chain reset (scan_rstb) on request. Sits between the on-chip config
//  master and the scan_chain instance, all in the scan_clk domain.
// PARAMETERS
//  N           64  chain length in bits; must equal the attached scan_chain N
//  RST_CYCLES  16  cycles scan_rstb is held low for a reset op (>=1)
// PORTS
//  scan_clk    in   1   single clock; all logic on posedge
//  scan_rst    in   1   synchronous, active-high reset
//  req_valid   in   1   request valid
//  req_ready   out  1   request accepted when req_valid & req_ready at posedge
//  req_op      in   1   0 = SHIFT (write/readback), 1 = CHAIN_RESET
//  req_wdata   in   N   word to load into chain (ignored for CHAIN_RESET)
//  resp_valid  out  1   response valid, held until resp_ready
//  resp_ready  in   1   response consumed when resp_valid & resp_ready at posedge
//  resp_rdata  out  N   previous chain contents (SHIFT) / all-zero (CHAIN_RESET)
//  scan_en     out  1   to chain: shift enable
//  scan_in     out  1   to chain: serial data
//  scan_rstb   out  1   to chain: active-low chain reset
//  scan_out    in   1   from chain: serial out = chain dout[N-1]
// BEHAVIOUR
//  - All outputs registered. During scan_rst: req_ready=0, resp_valid=0, resp_rdata=0, scan_en=0, scan_in=0, scan_rstb=0,
//    state=IDLE, counter=0. First cycle after reset deasserts: scan_rstb=1, req_ready=1.
//  - FSM: IDLE -> SHIFT (accept, op=0) | CRST (accept, op=1); SHIFT -> RESP after N shift cycles; CRST -> RESP after
//    RST_CYCLES; RESP -> IDLE on resp_valid & resp_ready.
//  - req_ready=1 only in IDLE. No new request is accepted while a response is pending.
//  - req_wdata is latched into the shift register at acceptance; later changes to req_wdata have no effect.
//  - SHIFT: accept at edge t. Cycles t+1..t+N have scan_en=1 and scan_in=wdata[N-1-i] for cycle i (i=0..N-1).
//    At the posedge ending cycle i, the driver samples scan_out into rdata[N-1-i] (pre-shift chain MSB). The chain
//    shifts on the same edge.
//    * After N shifts: chain dout == wdata exactly, and rdata == chain contents before the op.
//    * scan_en drops to 0 on cycle t+N+1, which is also the cycle resp_valid rises.
//    * Total: exactly N scan_en-high cycles; no extra shift.
//  - CRST: scan_rstb=0 and scan_en=0 for cycles t+1..t+RST_CYCLES. scan_rstb returns to 1 with resp_valid=1 and
//    resp_rdata=0.
//  - Counter width $clog2(N+1). It counts 0..N-1 (SHIFT) or 0..RST_CYCLES-1 (CRST) and clears in IDLE.
//  - resp_rdata is stable while resp_valid=1. resp_valid & resp_ready in the same cycle as a new req_valid: the
//    response retires this edge; the request is accepted no earlier than the next edge (IDLE).
//  - scan_rst mid-SHIFT/CRST aborts the op: no response is produced and outputs return to reset values next edge.
//    The chain is left partially shifted; with scan_rstb=0 during reset, the chain is cleared.
//  - scan_in is 0 whenever scan_en=0.
// TESTING (bench: scan_chain_driver wired to scan_chain N=64, scan_clk period 10)
//  1 Reset 16 cycles -> scan_rstb=0 throughout, chain dout=0; after release req_ready=1, scan_rstb=1, resp_valid=0.
//  2 SHIFT wdata=64'hDEAD_BEEF_0123_4567 on cleared chain -> exactly 64 scan_en cycles; chain dout=64'hDEAD_BEEF_0123_4567;
//    resp_rdata=0; resp_valid rises 65 cycles after accept.
//  3 Back-to-back SHIFT wdata=64'hFFFF_FFFF_FFFF_FFFF then 64'h0 -> second resp_rdata=64'hDEAD_BEEF_0123_4567,
//    third resp_rdata=64'hFFFF_FFFF_FFFF_FFFF; chain dout=0.
//  4 Response backpressure: resp_ready=0 for 10 cycles with req_valid=1 -> req_ready=0 and resp_rdata stable
//    throughout; chain dout unchanged.
//  5 CHAIN_RESET after loading 64'hA5A5_A5A5_A5A5_A5A5 -> scan_rstb low exactly 16 cycles; chain dout=0; resp_rdata=0.
//  6 scan_rst asserted at shift cycle 20 of SHIFT wdata=64'h1 -> no resp_valid; scan_en=0 next edge; chain dout=0
//    after reset; next SHIFT 64'h1 returns resp_rdata=0.

Source files
------------

// File: rtl/scan_chain_driver.sv
// scan_chain_driver: master end of a scan chain.
// Takes SHIFT / CHAIN_RESET requests and drives scan_en/scan_in/scan_rstb.
// SHIFT serializes the request word MSB-first and captures the previous
// chain contents from scan_out. CHAIN_RESET pulses scan_rstb low for
// RST_CYCLES cycles. Every output is a flop. The FSM state is mirrored on
// dbg_state so that checkers can bind to it.
//
// Handshake semantics, for both ports:
// - A transfer happens at a posedge where valid & ready are both 1.
// - req_ready is high only in IDLE.
// - resp_valid stays high, with resp_rdata frozen, until resp_ready is seen.
// - A response retiring on an edge returns the FSM to IDLE. The next request
//   is accepted no earlier than the following edge.
//
// Assumptions:
// - N >= 2.
// - RST_CYCLES fits in the $clog2(N+1)-bit counter (RST_CYCLES <= N).

module scan_chain_driver #(
    parameter int N          = 64,
    parameter int RST_CYCLES = 16
) (
    input  logic         scan_clk,
    input  logic         scan_rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_op,
    input  logic [N-1:0] req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [N-1:0] resp_rdata,
    output logic         scan_en,
    output logic         scan_in,
    output logic         scan_rstb,
    input  logic         scan_out,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CRST  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [CW-1:0] SHIFT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);

    logic [1:0]    state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [N-1:0]  sreg_q,       sreg_d;
    logic [N-1:0]  rdata_q,      rdata_d;
    logic          req_ready_q,  req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic          scan_en_q,    scan_en_d;
    logic          scan_in_q,    scan_in_d;
    logic          scan_rstb_q,  scan_rstb_d;

    // Next-state logic for the FSM, the shift/capture datapath and the registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sreg_d       = sreg_q;
        rdata_d      = rdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        scan_en_d    = scan_en_q;
        scan_in_d    = scan_in_q;
        scan_rstb_d  = scan_rstb_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                req_ready_d = 1'b1;
                scan_rstb_d = 1'b1;
                scan_en_d   = 1'b0;
                scan_in_d   = 1'b0;
                // Accept only once req_ready is visible on the port.
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    sreg_d      = req_wdata;
                    if (req_op) begin
                        state_d     = ST_CRST;
                        scan_rstb_d = 1'b0;
                    end else begin
                        state_d   = ST_SHIFT;
                        scan_en_d = 1'b1;
                        scan_in_d = req_wdata[N-1];
                    end
                end
            end

            ST_SHIFT: begin
                // The chain MSB is captured on the same edge that the chain shifts.
                // After N edges, rdata holds the old chain contents MSB-first.
                rdata_d = {rdata_q[N-2:0], scan_out};
                if (cnt_q == SHIFT_LAST) begin
                    state_d      = ST_RESP;
                    scan_en_d    = 1'b0;
                    scan_in_d    = 1'b0;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    sreg_d    = sreg_q << 1;
                    scan_in_d = sreg_q[N-2];
                end
            end

            ST_CRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d      = ST_RESP;
                    scan_rstb_d  = 1'b1;
                    resp_valid_d = 1'b1;
                    rdata_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any op in flight and holds the chain in reset.
    always_ff @(posedge scan_clk) begin
        if (scan_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sreg_q       <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            scan_en_q    <= 1'b0;
            scan_in_q    <= 1'b0;
            scan_rstb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sreg_q       <= sreg_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            scan_en_q    <= scan_en_d;
            scan_in_q    <= scan_in_d;
            scan_rstb_q  <= scan_rstb_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign scan_en    = scan_en_q;
    assign scan_in    = scan_in_q;
    assign scan_rstb  = scan_rstb_q;
    assign dbg_state  = state_q;

endmodule
